// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write bypass, two prioritised
// write ports, a per-register busy scoreboard and an unbypassed debug read tap.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data,
  output logic [NREG-1:0]     busy
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0] r_mem [NREG];
  logic [NREG-1:0] r_busy;

  logic [NREG-1:0] w_hit0;
  logic [NREG-1:0] w_hit1;
  logic [NREG-1:0] w_alloc;
  logic [AW-1:0]   w_ra [NRD];

  // Per-register strobes; register 0 never sees a strobe when it is hardwired.
  always_comb begin
    w_hit0  = '0;
    w_hit1  = '0;
    w_alloc = '0;
    for (int r = 0; r < NREG; r++) begin
      if (!(ZR && r == 0)) begin
        w_hit0[r]  = we0 && (waddr0 == AW'(r));
        w_hit1[r]  = we1 && (waddr1 == AW'(r));
        w_alloc[r] = alloc_en && (alloc_addr == AW'(r));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) r_mem[r] <= '0;
      r_busy <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_hit1[r])      r_mem[r] <= wdata1;
        else if (w_hit0[r]) r_mem[r] <= wdata0;
        // A fresh producer supersedes the one that is retiring this cycle.
        if (w_alloc[r])                  r_busy[r] <= 1'b1;
        else if (w_hit0[r] || w_hit1[r]) r_busy[r] <= 1'b0;
      end
    end
  end

  // Reads are gated by reset so a bypass hit cannot leak data while held in reset.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      w_ra[i] = raddr[i*AW +: AW];
      if (!rst) begin
        rdata[i*XLEN +: XLEN] = '0;
      end else if (ZR && (w_ra[i] == '0)) begin
        rdata[i*XLEN +: XLEN] = '0;
      end else if (we1 && (waddr1 == w_ra[i])) begin
        rdata[i*XLEN +: XLEN] = wdata1;
      end else if (we0 && (waddr0 == w_ra[i])) begin
        rdata[i*XLEN +: XLEN] = wdata0;
      end else begin
        rdata[i*XLEN +: XLEN] = r_mem[w_ra[i]];
        rbusy[i]              = r_busy[w_ra[i]];
      end
    end
  end

  assign dbg_data = r_mem[dbg_addr];
  assign busy     = r_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default configuration plus a 64-bit, 16-register,
// 4-port instance without a hardwired zero register.
module tb_regfile_mp;

  logic clk;
  logic rst;

  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [1:0]  a_rbusy;
  logic        a_we0, a_we1, a_alloc_en;
  logic [4:0]  a_waddr0, a_waddr1, a_alloc_addr, a_dbg_addr;
  logic [31:0] a_wdata0, a_wdata1, a_dbg_data, a_busy;

  logic [15:0]  b_raddr;
  logic [255:0] b_rdata;
  logic [3:0]   b_rbusy;
  logic         b_we0, b_we1, b_alloc_en;
  logic [3:0]   b_waddr0, b_waddr1, b_alloc_addr, b_dbg_addr;
  logic [63:0]  b_wdata0, b_wdata1, b_dbg_data;
  logic [15:0]  b_busy;

  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] m_mem [32];

  regfile_mp u_a (
    .clk(clk), .rst(rst), .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
    .we0(a_we0), .waddr0(a_waddr0), .wdata0(a_wdata0),
    .we1(a_we1), .waddr1(a_waddr1), .wdata1(a_wdata1),
    .alloc_en(a_alloc_en), .alloc_addr(a_alloc_addr),
    .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data), .busy(a_busy)
  );

  regfile_mp #(.XLEN(64), .NREG(16), .NRD(4), .ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst), .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
    .we0(b_we0), .waddr0(b_waddr0), .wdata0(b_wdata0),
    .we1(b_we1), .waddr1(b_waddr1), .wdata1(b_wdata1),
    .alloc_en(b_alloc_en), .alloc_addr(b_alloc_addr),
    .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data), .busy(b_busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_we0 = 0; a_we1 = 0; a_alloc_en = 0;
  endtask

  task automatic b_idle();
    b_we0 = 0; b_we1 = 0; b_alloc_en = 0;
  endtask

  // Scoreboard
  task automatic push(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=%h expected=<queue empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  function automatic logic [31:0] a_model_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (a_we1 && a_waddr1 == a) return a_wdata1;
    if (a_we0 && a_waddr0 == a) return a_wdata0;
    return m_mem[a];
  endfunction

  initial begin
    rst = 0;
    a_idle(); b_idle();
    a_raddr = '0; a_waddr0 = '0; a_waddr1 = '0; a_wdata0 = '0; a_wdata1 = '0;
    a_alloc_addr = '0; a_dbg_addr = '0;
    b_raddr = '0; b_waddr0 = '0; b_waddr1 = '0; b_wdata0 = '0; b_wdata1 = '0;
    b_alloc_addr = '0; b_dbg_addr = '0;
    for (int i = 0; i < 32; i++) m_mem[i] = '0;

    // Held in reset: bypass must not leak, inputs are ignored
    #2;
    a_we1 = 1; a_waddr1 = 5'd3; a_wdata1 = 32'd77; a_raddr = {5'd3, 5'd3};
    a_alloc_en = 1; a_alloc_addr = 5'd3; a_dbg_addr = 5'd3;
    #1;
    push(0); chk("reset_rdata0", a_rdata[31:0]);
    push(0); chk("reset_busy", a_busy);
    tick();
    push(0); chk("reset_edge_busy", a_busy);
    push(0); chk("reset_edge_dbg", a_dbg_data);
    a_idle();
    rst = 1;

    // Basic write / read
    a_we0 = 1; a_waddr0 = 5'd1; a_wdata0 = 32'd32;
    tick();
    a_waddr0 = 5'd31; a_wdata0 = 32'd21;
    tick();
    a_idle(); a_raddr = {5'd31, 5'd1}; a_dbg_addr = 5'd31;
    #1;
    push(32); chk("basic_rd0", a_rdata[31:0]);
    push(21); chk("basic_rd1", a_rdata[63:32]);
    push(21); chk("basic_dbg", a_dbg_data);

    // Port 1 wins a same-address conflict, bypassed combinationally
    a_we0 = 1; a_waddr0 = 5'd1; a_wdata0 = 32'd200;
    a_we1 = 1; a_waddr1 = 5'd1; a_wdata1 = 32'd2;
    a_raddr = {5'd31, 5'd1}; a_dbg_addr = 5'd1;
    #1;
    push(2);  chk("byp_prio_rd0", a_rdata[31:0]);
    push(32); chk("byp_dbg_committed", a_dbg_data);
    push(21); chk("byp_other_port", a_rdata[63:32]);
    tick();
    a_idle();
    #1;
    push(2); chk("prio_dbg_next", a_dbg_data);
    push(2); chk("prio_rd0_next", a_rdata[31:0]);

    // Port 0 bypass alone
    a_we0 = 1; a_waddr0 = 5'd10; a_wdata0 = 32'h55; a_raddr = {5'd10, 5'd1};
    #1;
    push(32'h55); chk("byp_we0_rd1", a_rdata[63:32]);
    tick();
    a_idle();

    // Scoreboard set then clear through write
    a_alloc_en = 1; a_alloc_addr = 5'd7; a_raddr = {5'd7, 5'd1};
    #1;
    push(0); chk("alloc_same_cycle_busy", a_busy);
    tick();
    a_idle();
    #1;
    push(32'h80); chk("alloc_busy", a_busy);
    push(2'b10);  chk("alloc_rbusy", a_rbusy);
    a_we1 = 1; a_waddr1 = 5'd7; a_wdata1 = 32'd9;
    #1;
    push(0);      chk("wb_rbusy", a_rbusy);
    push(9);      chk("wb_rd1_byp", a_rdata[63:32]);
    push(32'h80); chk("wb_busy_still", a_busy);
    tick();
    a_idle();
    #1;
    push(0); chk("wb_busy_clear", a_busy);
    push(9); chk("wb_rd1_stored", a_rdata[63:32]);

    // Alloc and write collide on one register: set wins
    a_alloc_en = 1; a_alloc_addr = 5'd3;
    a_we0 = 1; a_waddr0 = 5'd3; a_wdata0 = 32'd4; a_raddr = {5'd7, 5'd3};
    #1;
    push(4); chk("coll_rd0_byp", a_rdata[31:0]);
    push(0); chk("coll_rbusy_byp", a_rbusy);
    tick();
    a_idle();
    #1;
    push(4);     chk("coll_rd0", a_rdata[31:0]);
    push(32'h8); chk("coll_busy", a_busy);
    push(2'b01); chk("coll_rbusy", a_rbusy);
    a_we0 = 1; a_waddr0 = 5'd3; a_wdata0 = 32'd4;
    tick();
    a_idle();

    // Register 0 is hardwired
    a_we0 = 1; a_waddr0 = 5'd0; a_wdata0 = 32'h80;
    a_we1 = 1; a_waddr1 = 5'd0; a_wdata1 = 32'h81;
    a_alloc_en = 1; a_alloc_addr = 5'd0; a_raddr = {5'd1, 5'd0};
    #1;
    push(0); chk("zero_rd0_byp", a_rdata[31:0]);
    tick();
    a_idle(); a_dbg_addr = 5'd0;
    #1;
    push(0); chk("zero_dbg", a_dbg_data);
    push(0); chk("zero_busy", a_busy);
    push(0); chk("zero_rbusy", a_rbusy);
    push(0); chk("zero_rd0", a_rdata[31:0]);

    // Mid-cycle reset clears everything at once
    a_we0 = 1; a_waddr0 = 5'd5; a_wdata0 = 32'hDEAD;
    tick();
    a_idle();
    a_alloc_en = 1; a_alloc_addr = 5'd9; a_raddr = {5'd9, 5'd5}; a_dbg_addr = 5'd5;
    #1;
    push(32'hDEAD); chk("pre_rst_rd0", a_rdata[31:0]);
    tick();
    a_idle();
    #1;
    push(32'h200); chk("pre_rst_busy", a_busy);
    push(2'b10);   chk("pre_rst_rbusy", a_rbusy);
    #2;
    rst = 0;
    a_we1 = 1; a_waddr1 = 5'd5; a_wdata1 = 32'hBEEF; a_alloc_en = 1;
    #1;
    push(0); chk("rst_rd0", a_rdata[31:0]);
    push(0); chk("rst_dbg", a_dbg_data);
    push(0); chk("rst_busy", a_busy);
    push(0); chk("rst_rbusy", a_rbusy);
    tick();
    push(0); chk("rst_edge_busy", a_busy);
    push(0); chk("rst_edge_dbg", a_dbg_data);
    a_idle();
    rst = 1;
    a_we0 = 1; a_waddr0 = 5'd5; a_wdata0 = 32'h11;
    tick();
    a_idle();
    m_mem[5] = 32'h11;
    #1;
    push(32'h11); chk("post_rst_write", a_dbg_data);

    // Random traffic against a reference array
    for (int n = 0; n < 12; n++) begin
      a_we0 = 1'($urandom_range(0, 1));
      a_we1 = 1'($urandom_range(0, 1));
      a_waddr0 = 5'($urandom_range(0, 31));
      a_waddr1 = (n % 3 == 0) ? a_waddr0 : 5'($urandom_range(0, 31));
      a_wdata0 = $urandom;
      a_wdata1 = $urandom;
      a_raddr = {a_waddr1, 5'($urandom_range(0, 31))};
      a_dbg_addr = 5'($urandom_range(0, 31));
      #1;
      push(a_model_rd(a_raddr[4:0])); chk("rand_rd0", a_rdata[31:0]);
      push(a_model_rd(a_raddr[9:5])); chk("rand_rd1", a_rdata[63:32]);
      push(m_mem[a_dbg_addr]);        chk("rand_dbg", a_dbg_data);
      tick();
      if (a_we0 && a_waddr0 != 0) m_mem[a_waddr0] = a_wdata0;
      if (a_we1 && a_waddr1 != 0) m_mem[a_waddr1] = a_wdata1;
    end
    a_idle();

    // Wide, 4-port, register 0 is a normal register
    b_alloc_en = 1; b_alloc_addr = 4'd0;
    tick();
    b_idle(); b_raddr = {4'd3, 4'd2, 4'd1, 4'd0};
    #1;
    push(16'h0001); chk("b_alloc0_busy", b_busy);
    push(4'b0001);  chk("b_alloc0_rbusy", b_rbusy);
    b_we0 = 1; b_waddr0 = 4'd0; b_wdata0 = 64'h0123_4567_89AB_CDEF;
    b_we1 = 1; b_waddr1 = 4'd5; b_wdata1 = 64'hFEDC_BA98_7654_3210;
    #1;
    push(64'h0123_4567_89AB_CDEF); chk("b_byp_rd0", b_rdata[63:0]);
    push(0);                       chk("b_byp_rbusy", b_rbusy);
    tick();
    b_waddr0 = 4'd10; b_wdata0 = 64'hAAAA_5555_0000_FFFF;
    b_waddr1 = 4'd15; b_wdata1 = 64'h8000_0000_0000_0001;
    tick();
    b_idle(); b_raddr = {4'd0, 4'd5, 4'd10, 4'd15};
    #1;
    push(64'h8000_0000_0000_0001); chk("b_rd_p0", b_rdata[63:0]);
    push(64'hAAAA_5555_0000_FFFF); chk("b_rd_p1", b_rdata[127:64]);
    push(64'hFEDC_BA98_7654_3210); chk("b_rd_p2", b_rdata[191:128]);
    push(64'h0123_4567_89AB_CDEF); chk("b_rd_p3", b_rdata[255:192]);
    push(0);                       chk("b_busy_clear", b_busy);

    b_we0 = 1; b_waddr0 = 4'd12; b_wdata0 = 64'h1111_2222_3333_4444;
    b_we1 = 1; b_waddr1 = 4'd12; b_wdata1 = 64'h5555_6666_7777_8888;
    b_alloc_en = 1; b_alloc_addr = 4'd12;
    b_raddr = {4'd0, 4'd12, 4'd10, 4'd15};
    #1;
    push(64'h5555_6666_7777_8888); chk("b_prio_p2", b_rdata[191:128]);
    tick();
    b_idle(); b_dbg_addr = 4'd12;
    #1;
    push(64'h5555_6666_7777_8888); chk("b_prio_dbg", b_dbg_data);
    push(16'h1000);                chk("b_coll_busy", b_busy);
    push(4'b0100);                 chk("b_coll_rbusy", b_rbusy);

    // Final report
    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL leftover_expect: observed=%0d pending expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the core's decode/writeback boundary. It provides NRD combinational read ports with same-cycle write bypass and two prioritised write ports. A per-register busy scoreboard flags registers whose producer has issued but not yet written back, which lets issue stall on long-latency results. A debug read tap replaces the fixed single-register test output of the previous generation.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥ 2)
- AW, $clog2(NREG), register address width
- NRD, 2, number of read ports (1–4)
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never busy
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- raddr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW]
- rdata  out  NRD*XLEN  read data; port i at bits [i*XLEN +: XLEN]
- rbusy  out  NRD  port i's register has an outstanding producer
- we0, waddr0, wdata0  in  1, AW, XLEN  write port 0 (older instruction)
- we1, waddr1, wdata1  in  1, AW, XLEN  write port 1 (younger instruction; wins conflicts)
- alloc_en, alloc_addr  in  1, AW  mark a register busy (destination of a newly issued instruction)
- dbg_addr  in  AW  debug tap address
- dbg_data  out  XLEN  array contents at dbg_addr (no bypass)
- busy  out  NREG  full scoreboard vector

## Operation
- Storage: NREG×XLEN flip-flop array plus an NREG-bit busy vector.
- Reset (rst=0): array and busy cleared asynchronously, immediately. While rst=0, rdata, rbusy, dbg_data, and busy are all 0, and write/alloc inputs are ignored.
- Write: at a rising edge, if weN=1, then reg[waddrN] ← wdataN. If both ports target the same address, port 1's data is stored. With ZERO_REG=1, writes to address 0 are dropped.
- Read, per port i, evaluated in priority order:
  - ZERO_REG && raddr==0 → 0.
  - we1 && waddr1==raddr → wdata1.
  - we0 && waddr0==raddr → wdata0.
  - Otherwise reg[raddr].
  - Bypass is purely combinational.
- Scoreboard update at a rising edge, for each register r:
  - Alloc sets busy[r] if alloc_en && alloc_addr==r.
  - Otherwise a write clears busy[r] if (we0 && waddr0==r) || (we1 && waddr1==r).
  - Set has priority over clear for the same register in the same cycle, because the new producer supersedes the old one.
  - With ZERO_REG=1, busy[0] is held at 0.
- rbusy[i] = busy[raddr_i] && no bypass hit on port i. A register being written this cycle reads as ready with bypassed data. rbusy is forced 0 for address 0 when ZERO_REG=1.
- dbg_data = reg[dbg_addr]. It shows committed state only, with no bypass.
- Out-of-range addresses cannot occur, because NREG is a power of two.

## Timing
- Read latency: 0 cycles (combinational from raddr, we*, waddr*, wdata*).
- Write → array: visible on dbg_data and non-bypassed reads the cycle after the edge.
- Alloc → busy: busy/rbusy assert the cycle after the alloc edge.
- Clear → busy: busy deasserts the cycle after the write edge. rbusy drops in the write cycle itself through the bypass rule.
- Reset assertion mid-cycle: state and outputs clear immediately, without waiting for a clock edge.
- Reset release: the first write/alloc takes effect on the first rising edge after rst=1.
- Simultaneous alloc and write to the same register: data is written and busy is 1 the next cycle.
- Simultaneous we0/we1 to the same register: one write occurs, and port 1's data is stored and bypassed.

## Test plan
- Reset/zero:
  - Drive rst=0 mid-run after writing reg[5]=0xDEAD → rdata, dbg_data, and busy all read 0 at once.
  - After release, write 0x80 to reg 0 → reg 0 still reads 0, busy[0]=0.
- Basic write/read:
  - we0 writes reg1=32 and reg31=21 in consecutive cycles.
  - Next cycle raddr={1,31} → rdata={32,21}.
- Bypass and port priority:
  - In the same cycle, we0 writes reg1=200, we1 writes reg1=2, raddr0=1 → rdata0=2 combinationally.
  - Next cycle dbg_addr=1 → dbg_data=2.
- Scoreboard:
  - alloc reg7 → busy[7]=1 next cycle, rbusy=1 on a port reading 7.
  - we1 writes reg7=9 → rbusy=0 and rdata=9 in the same cycle; busy[7]=0 next cycle.
- Alloc/write collision: alloc reg3 and we0 write reg3=4 in the same cycle → next cycle reg3=4 and busy[3]=1.
- Parameter sweep: repeat the above with XLEN=64, NREG=16, NRD=4, ZERO_REG=0 → reg 0 is writable and busy-trackable, and all 4 ports read independently.
